// File: rtl/mdu_hilo.sv
// mdu_hilo
//   Iterative multiply/divide unit that owns the architectural HI/LO pair.
//   Executes MULT, MULTU and DIVU over WIDTH cycles, one bit per cycle, and
//   services MTHI/MTLO writes and MFHI/MFLO reads. All other decoded ALU
//   control codes are ignored.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     alu_control/src_a/src_b are valid this cycle
//   req_ready     high whenever the unit is idle; accept on valid && ready
//   alu_control   decoded operation code
//   src_a, src_b  rs / rt operands
//   busy          a multiply or divide is iterating
//   done          one-cycle pulse when HI/LO first show a new mul/div result
//   hi, lo        architectural HI and LO registers
//   mf_data       hi for MFHI, lo for MFLO, zero otherwise (combinational)

module mdu_hilo #(
    parameter int WIDTH              = 32,
    parameter int ALU_CONTROL_LENGTH = 5,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULT  = 5'd12,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULTU = 5'd13,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_DIVU  = 5'd14,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTHI  = 5'd15,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTLO  = 5'd16,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFHI  = 5'd17,
    parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFLO  = 5'd18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
    input  logic [WIDTH-1:0]              src_a,
    input  logic [WIDTH-1:0]              src_b,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              hi,
    output logic [WIDTH-1:0]              lo,
    output logic [WIDTH-1:0]              mf_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {OP_MULTU, OP_MULT, OP_DIVU} op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // acc: partial product high half / partial remainder
    // shr: multiplier being consumed / dividend shifting out, quotient shifting in
    // opnd: multiplicand magnitude / divisor
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  shr_q, shr_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_acc_nx, mul_shr_nx;
    logic [2*WIDTH-1:0] product, product_signed;
    logic [WIDTH:0]    div_rem_sh;
    logic              div_ge;
    logic [WIDTH-1:0]  div_diff, div_acc_nx, div_shr_nx;
    logic [WIDTH-1:0]  abs_a, abs_b;

    // One iteration of each algorithm, evaluated every cycle from the
    // shared working registers. The multiply adds the multiplicand when the
    // current multiplier LSB is set and shifts the WIDTH+1 bit sum right
    // into the low half. The divide shifts the next dividend bit into the
    // remainder and subtracts the divisor when it fits. A zero divisor
    // always "fits", which yields an all-ones quotient and leaves the whole
    // dividend in the remainder after WIDTH steps.
    always_comb begin
        mul_sum        = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_nx     = mul_sum[WIDTH:1];
        mul_shr_nx     = {mul_sum[0], shr_q[WIDTH-1:1]};
        product        = {mul_acc_nx, mul_shr_nx};
        product_signed = neg_q ? (~product + 1'b1) : product;

        div_rem_sh     = {acc_q, shr_q[WIDTH-1]};
        div_ge         = (div_rem_sh >= {1'b0, opnd_q});
        div_diff       = div_rem_sh[WIDTH-1:0] - opnd_q;
        div_acc_nx     = div_ge ? div_diff : div_rem_sh[WIDTH-1:0];
        div_shr_nx     = {shr_q[WIDTH-2:0], div_ge};

        abs_a          = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
        abs_b          = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;
    end

    // Next-state logic. In IDLE a valid request either starts an iteration
    // (operands latched, counter cleared) or performs an MT* write; unknown
    // codes leave everything untouched. In RUN the final iteration writes
    // HI/LO directly from the combinational next values so the result lands
    // on the same edge that returns the FSM to IDLE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shr_d   = shr_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (alu_control)
                        ALU_CONTROL_MULTU: begin
                            state_d = RUN;
                            op_d    = OP_MULTU;
                            cnt_d   = '0;
                            acc_d   = '0;
                            shr_d   = src_b;
                            opnd_d  = src_a;
                            neg_d   = 1'b0;
                        end
                        ALU_CONTROL_MULT: begin
                            state_d = RUN;
                            op_d    = OP_MULT;
                            cnt_d   = '0;
                            acc_d   = '0;
                            shr_d   = abs_b;
                            opnd_d  = abs_a;
                            neg_d   = src_a[WIDTH-1] ^ src_b[WIDTH-1];
                        end
                        ALU_CONTROL_DIVU: begin
                            state_d = RUN;
                            op_d    = OP_DIVU;
                            cnt_d   = '0;
                            acc_d   = '0;
                            shr_d   = src_a;
                            opnd_d  = src_b;
                            neg_d   = 1'b0;
                        end
                        ALU_CONTROL_MTHI: hi_d = src_a;
                        ALU_CONTROL_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_DIVU) begin
                    acc_d = div_acc_nx;
                    shr_d = div_shr_nx;
                end else begin
                    acc_d = mul_acc_nx;
                    shr_d = mul_shr_nx;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (op_q == OP_DIVU) begin
                        hi_d = div_acc_nx;
                        lo_d = div_shr_nx;
                    end else begin
                        hi_d = product_signed[2*WIDTH-1:WIDTH];
                        lo_d = product_signed[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register bank; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_MULTU;
            cnt_q   <= '0;
            acc_q   <= '0;
            shr_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shr_q   <= shr_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // MF* reads need no handshake and always see the current registers.
    always_comb begin
        mf_data = '0;
        if (alu_control == ALU_CONTROL_MFHI) begin
            mf_data = hi_q;
        end else if (alu_control == ALU_CONTROL_MFLO) begin
            mf_data = lo_q;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

    localparam logic [4:0] NOP   = 5'd0;
    localparam logic [4:0] MULT  = 5'd12;
    localparam logic [4:0] MULTU = 5'd13;
    localparam logic [4:0] DIVU  = 5'd14;
    localparam logic [4:0] MTHI  = 5'd15;
    localparam logic [4:0] MTLO  = 5'd16;
    localparam logic [4:0] MFHI  = 5'd17;
    localparam logic [4:0] MFLO  = 5'd18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  alu_control = NOP;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int total = 0;
    int bad = 0;

    mdu_hilo dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    // Present one request for a single edge; called 1 time unit after an edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        alu_control = op;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        alu_control = NOP;
    endtask

    // Step cycles until done shows, counting busy cycles; bounded.
    task automatic wait_done(output int cnt, output bit timeout);
        cnt = 0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        total++; if (hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h want %h", hi, 32'h0); end
        total++; if (lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h want %h", lo, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_multu();
        int cnt;
        bit to;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cnt, to);
        total++; if (to) begin bad++; $display("[TB] FAIL multu_timeout: got no done want done"); end
        total++; if (cnt !== 32) begin bad++; $display("[TB] FAIL multu_busy_cycles: got %0d want 32", cnt); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL multu_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("[TB] FAIL multu_lo: got %h want 00000001", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL multu_busy_after: got %b want 0", busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL multu_done_pulse: got %b want 0", done); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("[TB] FAIL multu_hi_hold: got %h want fffffffe", hi); end
    endtask

    task automatic test_mult();
        logic [31:0] va[4] = '{32'hFFFFFFFD, 32'h80000000, 32'h00000007, 32'hFFFFFFFF};
        logic [31:0] vb[4] = '{32'h00000005, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] eh[4] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] el[4] = '{32'hFFFFFFF1, 32'h00000000, 32'hFFFFFFF2, 32'h00000001};
        int cnt;
        bit to;
        for (int k = 0; k < 4; k++) begin
            issue(MULT, va[k], vb[k]);
            wait_done(cnt, to);
            total++; if (to || cnt !== 32) begin bad++; $display("[TB] FAIL mult%0d_timing: got busy=%0d timeout=%b want 32 0", k, cnt, to); end
            total++; if (hi !== eh[k]) begin bad++; $display("[TB] FAIL mult%0d_hi: got %h want %h", k, hi, eh[k]); end
            total++; if (lo !== el[k]) begin bad++; $display("[TB] FAIL mult%0d_lo: got %h want %h", k, lo, el[k]); end
        end
    endtask

    task automatic test_divu();
        logic [31:0] va[3] = '{32'd100, 32'h00001234, 32'hFFFFFFFF};
        logic [31:0] vb[3] = '{32'd7,   32'h00000000, 32'h00000001};
        logic [31:0] eh[3] = '{32'h00000002, 32'h00001234, 32'h00000000};
        logic [31:0] el[3] = '{32'h0000000E, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int cnt;
        bit to;
        for (int k = 0; k < 3; k++) begin
            issue(DIVU, va[k], vb[k]);
            wait_done(cnt, to);
            total++; if (to || cnt !== 32) begin bad++; $display("[TB] FAIL divu%0d_timing: got busy=%0d timeout=%b want 32 0", k, cnt, to); end
            total++; if (hi !== eh[k]) begin bad++; $display("[TB] FAIL divu%0d_hi: got %h want %h", k, hi, eh[k]); end
            total++; if (lo !== el[k]) begin bad++; $display("[TB] FAIL divu%0d_lo: got %h want %h", k, lo, el[k]); end
        end
    endtask

    task automatic test_mt_mf();
        int hold_errs;
        bit seen_done;
        issue(MTHI, 32'hA5A5A5A5, 32'h0);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done); end
        alu_control = MFHI;
        #1;
        total++; if (mf_data !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL mfhi: got %h want a5a5a5a5", mf_data); end
        alu_control = NOP;
        issue(MTLO, 32'h5A5A0F0F, 32'h0);
        alu_control = MFLO;
        #1;
        total++; if (mf_data !== 32'h5A5A0F0F) begin bad++; $display("[TB] FAIL mflo: got %h want 5a5a0f0f", mf_data); end
        alu_control = NOP;
        #1;
        total++; if (mf_data !== 32'h0) begin bad++; $display("[TB] FAIL mf_other: got %h want 0", mf_data); end
        @(posedge clk); #1;
        // Unknown code must be ignored.
        issue(5'd3, 32'h11111111, 32'h22222222);
        total++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A0F0F || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL unknown_op: got hi=%h lo=%h busy=%b ready=%b want a5a5a5a5 5a5a0f0f 0 1", hi, lo, busy, req_ready);
        end
        // MTLO held upstream across a DIVU.
        issue(DIVU, 32'd100, 32'd7);
        req_valid = 1'b1;
        alu_control = MTLO;
        src_a = 32'h13579BDF;
        hold_errs = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (req_ready !== 1'b0 || lo !== 32'h5A5A0F0F) hold_errs++;
            @(posedge clk); #1;
        end
        total++; if (!seen_done) begin bad++; $display("[TB] FAIL mtlo_hold_timeout: got no done want done"); end
        total++; if (hold_errs !== 0) begin bad++; $display("[TB] FAIL mtlo_hold_busy: got %0d bad cycles want 0", hold_errs); end
        total++; if (req_ready !== 1'b1 || lo !== 32'h0000000E || hi !== 32'h00000002) begin
            bad++; $display("[TB] FAIL mtlo_done_cycle: got ready=%b hi=%h lo=%h want 1 00000002 0000000e", req_ready, hi, lo);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        alu_control = NOP;
        total++; if (lo !== 32'h13579BDF || hi !== 32'h00000002) begin
            bad++; $display("[TB] FAIL mtlo_after: got hi=%h lo=%h want 00000002 13579bdf", hi, lo);
        end
    endtask

    task automatic test_reset_midop();
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("[TB] FAIL midrst_hilo: got hi=%h lo=%h want 0 0", hi, lo); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL midrst_flags: got busy=%b done=%b ready=%b want 0 0 1", busy, done, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("[TB] FAIL midrst_after: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit to;
        issue(MULTU, 32'h00010000, 32'h00030000);
        wait_done(cnt, to);
        total++; if (to) begin bad++; $display("[TB] FAIL b2b_mul_timeout: got no done want done"); end
        total++; if (hi !== 32'h00000003 || lo !== 32'h0 || req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_mul_result: got hi=%h lo=%h ready=%b want 00000003 0 1", hi, lo, req_ready);
        end
        issue(DIVU, 32'd1000, 32'd33);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done(cnt, to);
        total++; if (to || cnt !== 32) begin bad++; $display("[TB] FAIL b2b_div_timing: got busy=%0d timeout=%b want 32 0", cnt, to); end
        total++; if (hi !== 32'd10 || lo !== 32'd30) begin bad++; $display("[TB] FAIL b2b_div_result: got hi=%h lo=%h want 0000000a 0000001e", hi, lo); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done_clear: got %b want 0", done); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_multu();
        test_mult();
        test_divu();
        test_mt_mf();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
